// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back path.
//   wb_state_t : sequencer state encoding (IDLE, READ_OLD, WRITE)
//   wb_req_t   : write-port requester identity for round-robin arbitration
package regfile_wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_BE_W   = 4;

  localparam logic [WB_ADDR_W-1:0] LINK_REG_DEFAULT = 5'd31;
  localparam logic [WB_BE_W-1:0]   FULL_BE          = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    READ_OLD = 2'b01,
    WRITE    = 2'b10
  } wb_state_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } wb_req_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: lanes with i_be set come from i_new,
// the rest keep i_old. Also used by the load/store alignment unit.
//   i_old      : current word
//   i_new      : lane-aligned replacement data
//   i_be       : per-byte lane enables
//   o_merged_c : merged word (combinational)
module byte_lane_merge
  import regfile_wb_pkg::*;
(
  input  logic [WB_DATA_W-1:0] i_old,
  input  logic [WB_DATA_W-1:0] i_new,
  input  logic [WB_BE_W-1:0]   i_be,
  output logic [WB_DATA_W-1:0] o_merged_c
);

  always_comb begin
    o_merged_c = i_old;
    for (int i = 0; i < int'(WB_BE_W); i++) begin
      if (i_be[i]) o_merged_c[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Write-back sequencer/arbiter for the single register-file write port.
// Arbitrates ALU/link and load requests round-robin, redirects link writes,
// suppresses $zero / empty-lane writes and performs partial loads as
// read-modify-write through the asynchronous read port.
//   clk, reset                : clock, synchronous active-high reset
//   alu_valid/ready/dest/data : ALU write-back request; alu_link forces LINK_REG
//   mem_valid/ready/dest/data : load write-back request; mem_be selects lanes
//   rf_raddr / rf_rdata       : register-file read port (old value for merges)
//   rf_we / rf_waddr / rf_wdata : register-file write port
//   busy                      : a write-back is in flight
module regfile_wb_sequencer
  import regfile_wb_pkg::*;
#(
  parameter int unsigned         DATA_W   = WB_DATA_W,
  parameter int unsigned         ADDR_W   = WB_ADDR_W,
  parameter logic [ADDR_W-1:0]   LINK_REG = ADDR_W'(LINK_REG_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              alu_link,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  wb_state_t          r_state;
  wb_req_t            r_last_grant;
  logic               r_alu_ready;
  logic               r_mem_ready;
  logic               r_rf_we;
  logic [ADDR_W-1:0]  r_rf_waddr;
  logic [DATA_W-1:0]  r_rf_wdata;
  logic [ADDR_W-1:0]  r_rf_raddr;
  logic [DATA_W-1:0]  r_mem_data;
  logic [3:0]         r_mem_be;

  logic [ADDR_W-1:0]  w_alu_dest_eff;
  logic               w_alu_acc;
  logic               w_mem_acc;
  logic               w_alu_null;
  logic               w_mem_null;
  logic               w_mem_partial;
  logic               w_grant_alu;
  logic               w_grant_mem;
  logic [DATA_W-1:0]  w_merged;

  assign w_alu_dest_eff = alu_link ? LINK_REG : alu_dest;
  assign w_alu_acc      = alu_valid & alu_ready;
  assign w_mem_acc      = mem_valid & mem_ready;
  assign w_alu_null     = (w_alu_dest_eff == '0);
  assign w_mem_null     = (mem_dest == '0) || (mem_be == 4'b0000);
  assign w_mem_partial  = !w_mem_null && (mem_be != FULL_BE);

  // Round-robin: a lone requester wins, contention goes to the one not served last.
  assign w_grant_alu = alu_valid & (~mem_valid | (r_last_grant == REQ_MEM));
  assign w_grant_mem = mem_valid & (~alu_valid | (r_last_grant == REQ_ALU));

  // Old register value merged with the captured load lanes during READ_OLD.
  byte_lane_merge u_merge (
    .i_old      (rf_rdata),
    .i_new      (r_mem_data),
    .i_be       (r_mem_be),
    .o_merged_c (w_merged)
  );

  // Sequencer FSM and registered write-port / ready outputs.
  // Readies are registered from the previous cycle's valids, so they never
  // combinationally depend on the current valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_ALU;
      r_alu_ready  <= 1'b0;
      r_mem_ready  <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_rf_raddr   <= '0;
      r_mem_data   <= '0;
      r_mem_be     <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_alu_acc) begin
            r_last_grant <= REQ_ALU;
            r_alu_ready  <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_state      <= WRITE;
            if (!w_alu_null) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= w_alu_dest_eff;
              r_rf_wdata <= alu_data;
            end
          end else if (w_mem_acc) begin
            r_last_grant <= REQ_MEM;
            r_alu_ready  <= 1'b0;
            r_mem_ready  <= 1'b0;
            if (w_mem_partial) begin
              // Destination parks in the read address; reused as write address.
              r_state    <= READ_OLD;
              r_rf_raddr <= mem_dest;
              r_mem_data <= mem_data;
              r_mem_be   <= mem_be;
            end else begin
              r_state <= WRITE;
              if (!w_mem_null) begin
                r_rf_we    <= 1'b1;
                r_rf_waddr <= mem_dest;
                r_rf_wdata <= mem_data;
              end
            end
          end else begin
            r_alu_ready <= w_grant_alu;
            r_mem_ready <= w_grant_mem;
          end
        end
        READ_OLD: begin
          r_state    <= WRITE;
          r_rf_we    <= 1'b1;
          r_rf_waddr <= r_rf_raddr;
          r_rf_wdata <= w_merged;
        end
        WRITE: begin
          r_state     <= IDLE;
          r_rf_we     <= 1'b0;
          r_alu_ready <= w_grant_alu;
          r_mem_ready <= w_grant_mem;
        end
        default: begin
          r_state     <= IDLE;
          r_rf_we     <= 1'b0;
          r_alu_ready <= 1'b0;
          r_mem_ready <= 1'b0;
        end
      endcase
    end
  end

  // Readies drop immediately when reset is asserted.
  assign alu_ready = r_alu_ready & ~reset;
  assign mem_ready = r_mem_ready & ~reset;
  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign rf_raddr  = r_rf_raddr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Bench for regfile_wb_sequencer: models the register file, predicts every
// write (timing, address, merged data) from the accepted requests, and checks
// arbitration, reset behaviour and final register contents.
module tb_regfile_wb_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, alu_link;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [4:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata;
  logic        rf_we, busy;

  regfile_wb_sequencer dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest),
    .alu_data(alu_data), .alu_link(alu_link),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest),
    .mem_data(mem_data), .mem_be(mem_be),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_rf  [32];
  logic [31:0] ref_rf [32];
  assign rf_rdata = tb_rf[rf_raddr];

  typedef struct {
    int          due;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          nul;
    bit          part;
  } exp_t;

  exp_t        q[$];
  int          grants[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          we_count = 0;
  bit          tb_last_mem = 1'b0;
  bit          prev_alu_v = 1'b0;
  bit          prev_mem_v = 1'b0;
  logic        poke_en = 1'b0;
  logic [4:0]  poke_a  = '0;
  logic [31:0] poke_v  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Register-file model plus write prediction from accepted requests.
  always @(posedge clk) begin
    exp_t        e;
    logic        exp_we;
    logic [31:0] mask;
    logic [31:0] merged;
    if (cyc == 0) begin
      for (int i = 0; i < 32; i++) begin
        ref_rf[i] = (i == 0) ? 32'h0 : $urandom;
        tb_rf[i] <= ref_rf[i];
      end
    end
    if (poke_en) begin
      ref_rf[poke_a] = poke_v;
      tb_rf[poke_a] <= poke_v;
    end
    if (rf_we) begin
      tb_rf[rf_waddr] <= rf_wdata;
      we_count++;
    end
    exp_we = 1'b0;
    if (reset) begin
      q.delete();
      tb_last_mem = 1'b0;
    end else begin
      if (q.size() > 0) begin
        e = q[0];
        if (e.part && e.due == cyc + 1) check("raddr", 32'(rf_raddr), 32'(e.a));
        if (e.due == cyc) begin
          void'(q.pop_front());
          if (!e.nul) begin
            exp_we = 1'b1;
            mask = 32'h0;
            for (int b = 0; b < 4; b++) if (e.be[b]) mask = mask | (32'hFF << (8 * b));
            merged = (ref_rf[e.a] & ~mask) | (e.d & mask);
            check("waddr", 32'(rf_waddr), 32'(e.a));
            check("wdata", rf_wdata, merged);
            ref_rf[e.a] = merged;
          end
        end
      end
      check("ready_excl", 32'(alu_ready & mem_ready), 32'd0);
      if (alu_ready | mem_ready) check("ready_busy", 32'(busy), 32'd0);
      if (alu_valid && mem_valid && prev_alu_v && prev_mem_v && (alu_ready | mem_ready))
        check("rr_grant", 32'(mem_ready), 32'(!tb_last_mem));
      if (alu_valid && alu_ready) begin
        e.a    = alu_link ? 5'd31 : alu_dest;
        e.d    = alu_data;
        e.be   = 4'hF;
        e.nul  = (e.a == 5'd0);
        e.part = 1'b0;
        e.due  = cyc + 1;
        q.push_back(e);
        tb_last_mem = 1'b0;
        grants.push_back(0);
      end
      if (mem_valid && mem_ready) begin
        e.a    = mem_dest;
        e.d    = mem_data;
        e.be   = mem_be;
        e.nul  = (mem_dest == 5'd0) || (mem_be == 4'h0);
        e.part = !e.nul && (mem_be != 4'hF);
        e.due  = cyc + (e.part ? 2 : 1);
        q.push_back(e);
        tb_last_mem = 1'b1;
        grants.push_back(1);
      end
    end
    check("we", 32'(rf_we), 32'(exp_we));
    prev_alu_v = alu_valid;
    prev_mem_v = mem_valid;
    cyc++;
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic alu_req(input logic [4:0] d, input logic [31:0] v, input logic l);
    bit got;
    alu_dest = d; alu_data = v; alu_link = l; alu_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk);
      got = alu_ready;
    end
    if (!got) check("alu_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    alu_valid = 1'b0;
  endtask

  task automatic mem_req(input logic [4:0] d, input logic [31:0] v, input logic [3:0] be);
    bit got;
    mem_dest = d; mem_data = v; mem_be = be; mem_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk);
      got = mem_ready;
    end
    if (!got) check("mem_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(rf_we),     32'd0);
    check({tag, "_waddr"}, 32'(rf_waddr),  32'd0);
    check({tag, "_wdata"}, rf_wdata,       32'd0);
    check({tag, "_raddr"}, 32'(rf_raddr),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_ardy"},  32'(alu_ready), 32'd0);
    check({tag, "_mrdy"},  32'(mem_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] saved;
    int          wc;
    logic [3:0]  be;
    reset = 1'b1;
    alu_valid = 1'b0; alu_dest = '0; alu_data = '0; alu_link = 1'b0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0; mem_be = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Full ALU write
    alu_req(5'd8, 32'hDEADBEEF, 1'b0);
    wait_idle();
    check("t1_r8", tb_rf[8], 32'hDEADBEEF);

    // Link write redirects to R31
    saved = ref_rf[4];
    alu_req(5'd4, 32'h00400010, 1'b1);
    wait_idle();
    check("t2_r31", tb_rf[31], 32'h00400010);
    check("t2_r4", tb_rf[4], saved);

    // Partial load merges into old value
    poke_a = 5'd9; poke_v = 32'h11223344; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    @(negedge clk);
    mem_req(5'd9, 32'h5555AABB, 4'b0011);
    wait_idle();
    check("t3_r9", tb_rf[9], 32'h1122AABB);

    // Null writes: $zero destination and empty lane mask
    wc = we_count;
    alu_req(5'd0, 32'hFFFFFFFF, 1'b0);
    mem_req(5'd12, 32'hCAFEF00D, 4'b0000);
    wait_idle();
    check("t5_no_we", 32'(we_count), 32'(wc));
    check("t5_r0", tb_rf[0], 32'h0);

    // Reset during READ_OLD abandons the partial write
    saved = ref_rf[5];
    mem_req(5'd5, 32'h00AB0000, 4'b0100);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rdy_in_rst", 32'(alu_ready | mem_ready), 32'd0);
    @(negedge clk);
    check_reset_outputs("t6");
    reset = 1'b0;
    @(negedge clk);
    check("t6_r5", tb_rf[5], saved);

    // Contention right after reset: MEM, ALU, MEM, ALU
    grants.delete();
    fork
      begin
        alu_req(5'd20, 32'hA0A0A0A0, 1'b0);
        alu_req(5'd21, 32'hA1A1A1A1, 1'b0);
      end
      begin
        mem_req(5'd22, 32'hB0B0B0B0, 4'hF);
        mem_req(5'd23, 32'hB1B1B1B1, 4'hF);
      end
    join
    wait_idle();
    check("t4_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'd99,
            (i % 2 == 0) ? 32'd1 : 32'd0);
    check("t4_r21", tb_rf[21], 32'hA1A1A1A1);
    check("t4_r23", tb_rf[23], 32'hB1B1B1B1);

    // Randomized mixed traffic
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          alu_req(5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 3) == 0));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          be = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
          mem_req(5'($urandom_range(0, 31)), $urandom, be);
        end
      end
    join
    wait_idle();

    for (int i = 0; i < 32; i++)
      check($sformatf("final_r%0d", i), tb_rf[i], ref_rf[i]);
    check("final_r0_zero", tb_rf[0], 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
